// File: rtl/min_sum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : min_sum_pkg
//  Purpose  : Shared constants for the min-sum check-node datapath: the
//             default magnitude width and the width of a lane index.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package min_sum_pkg;

  // Default unsigned magnitude width of every tree input and of min1/min2.
  localparam int W_DEFAULT = 5;

  // Index width: eight lanes need three bits.
  localparam int IDX_W = 3;

  // Number of lanes folded by the tree.
  localparam int N_LANES = 8;

endpackage : min_sum_pkg
`default_nettype wire

// File: rtl/min_sum_tree_8_if.sv
`default_nettype none
// ============================================================================
//  Module   : min_sum_tree_8_if
//  Purpose  : Bundles the input set (in_valid, x0..x7) and the result
//             (min1, min2, min1_index, out_valid) of min_sum_tree_8.
//  Ports    : clk - clock, visible to both sides of the bundle
//  Modports : master - produces inputs, consumes results
//             slave  - consumes inputs, produces results
//  Revision : 1.0 - initial release
// ============================================================================
interface min_sum_tree_8_if
  import min_sum_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input wire logic clk
);

  logic             in_valid;
  logic [W-1:0]     x0;
  logic [W-1:0]     x1;
  logic [W-1:0]     x2;
  logic [W-1:0]     x3;
  logic [W-1:0]     x4;
  logic [W-1:0]     x5;
  logic [W-1:0]     x6;
  logic [W-1:0]     x7;
  logic [W-1:0]     min1;
  logic [W-1:0]     min2;
  logic [IDX_W-1:0] min1_index;
  logic             out_valid;

  modport master (
    input  clk,
    output in_valid, x0, x1, x2, x3, x4, x5, x6, x7,
    input  min1, min2, min1_index, out_valid
  );

  modport slave (
    input  clk,
    input  in_valid, x0, x1, x2, x3, x4, x5, x6, x7,
    output min1, min2, min1_index, out_valid
  );

endinterface : min_sum_tree_8_if
`default_nettype wire

// File: rtl/min_sum_cs_node.sv
`default_nettype none
// ============================================================================
//  Module   : min_sum_cs_node
//  Purpose  : Combinational compare-select node. Merges two
//             (min, second, idx) tuples into one. The "a" operand is the
//             lower-index (left) side and wins when the two mins are equal,
//             which makes the whole tree resolve ties toward the lowest lane.
//  Ports    : i_a_min/i_a_sec/i_a_idx - left tuple
//             i_b_min/i_b_sec/i_b_idx - right tuple
//             o_min/o_sec/o_idx       - merged tuple
//  Revision : 1.0 - initial release
// ============================================================================
module min_sum_cs_node
  import min_sum_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  wire logic [W-1:0]     i_a_min,
  input  wire logic [W-1:0]     i_a_sec,
  input  wire logic [IDX_W-1:0] i_a_idx,
  input  wire logic [W-1:0]     i_b_min,
  input  wire logic [W-1:0]     i_b_sec,
  input  wire logic [IDX_W-1:0] i_b_idx,
  output logic      [W-1:0]     o_min,
  output logic      [W-1:0]     o_sec,
  output logic      [IDX_W-1:0] o_idx
);

  logic         w_b_wins;
  logic [W-1:0] w_loser_min;
  logic [W-1:0] w_winner_sec;

  // Strict compare: equal mins keep the left operand.
  assign w_b_wins = (i_b_min < i_a_min);

  always_comb begin
    o_min        = i_a_min;
    o_idx        = i_a_idx;
    w_winner_sec = i_a_sec;
    w_loser_min  = i_b_min;
    if (w_b_wins) begin
      o_min        = i_b_min;
      o_idx        = i_b_idx;
      w_winner_sec = i_b_sec;
      w_loser_min  = i_a_min;
    end
    // The runner-up is either the loser's best or the winner's own runner-up.
    o_sec = (w_loser_min < w_winner_sec) ? w_loser_min : w_winner_sec;
  end

endmodule : min_sum_cs_node
`default_nettype wire

// File: rtl/min_sum_tree_8.sv
`default_nettype none
// ============================================================================
//  Module   : min_sum_tree_8
//  Purpose  : Finds the smallest and second smallest of eight unsigned
//             magnitudes plus the lane index of the smallest, using a
//             3-level combinational compare-select tree followed by a single
//             output register stage (latency 1, throughput 1/cycle).
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low reset
//             in_valid   - qualifies x0..x7 this cycle
//             x0..x7     - input magnitudes, x0 is lane 0
//             min1       - smallest input
//             min2       - second smallest input (duplicates counted)
//             min1_index - lane of min1, lowest lane on ties
//             out_valid  - in_valid delayed by one cycle
//  Revision : 1.0 - initial release
// ============================================================================
module min_sum_tree_8
  import min_sum_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             in_valid,
  input  wire logic [W-1:0]     x0,
  input  wire logic [W-1:0]     x1,
  input  wire logic [W-1:0]     x2,
  input  wire logic [W-1:0]     x3,
  input  wire logic [W-1:0]     x4,
  input  wire logic [W-1:0]     x5,
  input  wire logic [W-1:0]     x6,
  input  wire logic [W-1:0]     x7,
  output logic      [W-1:0]     min1,
  output logic      [W-1:0]     min2,
  output logic      [IDX_W-1:0] min1_index,
  output logic                  out_valid
);

  logic [W-1:0]     w_x      [N_LANES];

  logic [W-1:0]     w_l1_min [4];
  logic [W-1:0]     w_l1_sec [4];
  logic [IDX_W-1:0] w_l1_idx [4];

  logic [W-1:0]     w_l2_min [2];
  logic [W-1:0]     w_l2_sec [2];
  logic [IDX_W-1:0] w_l2_idx [2];

  logic [W-1:0]     w_root_min;
  logic [W-1:0]     w_root_sec;
  logic [IDX_W-1:0] w_root_idx;

  logic [W-1:0]     min1_d,       min1_q;
  logic [W-1:0]     min2_d,       min2_q;
  logic [IDX_W-1:0] min1_index_d, min1_index_q;
  logic             out_valid_d,  out_valid_q;

  assign w_x[0] = x0;
  assign w_x[1] = x1;
  assign w_x[2] = x2;
  assign w_x[3] = x3;
  assign w_x[4] = x4;
  assign w_x[5] = x5;
  assign w_x[6] = x6;
  assign w_x[7] = x7;

  // Level 1: each raw input is a tuple whose "second" is its partner input,
  // so the merged second of a pair is simply the pair's larger value.
  generate
    for (genvar i = 0; i < 4; i++) begin : g_level1
      min_sum_cs_node #(.W(W)) u_node (
        .i_a_min (w_x[2*i]),
        .i_a_sec (w_x[2*i+1]),
        .i_a_idx (IDX_W'(2*i)),
        .i_b_min (w_x[2*i+1]),
        .i_b_sec (w_x[2*i]),
        .i_b_idx (IDX_W'(2*i+1)),
        .o_min   (w_l1_min[i]),
        .o_sec   (w_l1_sec[i]),
        .o_idx   (w_l1_idx[i])
      );
    end : g_level1

    for (genvar j = 0; j < 2; j++) begin : g_level2
      min_sum_cs_node #(.W(W)) u_node (
        .i_a_min (w_l1_min[2*j]),
        .i_a_sec (w_l1_sec[2*j]),
        .i_a_idx (w_l1_idx[2*j]),
        .i_b_min (w_l1_min[2*j+1]),
        .i_b_sec (w_l1_sec[2*j+1]),
        .i_b_idx (w_l1_idx[2*j+1]),
        .o_min   (w_l2_min[j]),
        .o_sec   (w_l2_sec[j]),
        .o_idx   (w_l2_idx[j])
      );
    end : g_level2
  endgenerate

  min_sum_cs_node #(.W(W)) u_root (
    .i_a_min (w_l2_min[0]),
    .i_a_sec (w_l2_sec[0]),
    .i_a_idx (w_l2_idx[0]),
    .i_b_min (w_l2_min[1]),
    .i_b_sec (w_l2_sec[1]),
    .i_b_idx (w_l2_idx[1]),
    .o_min   (w_root_min),
    .o_sec   (w_root_sec),
    .o_idx   (w_root_idx)
  );

  // Results are captured only for qualified input sets and held otherwise.
  always_comb begin
    min1_d       = min1_q;
    min2_d       = min2_q;
    min1_index_d = min1_index_q;
    out_valid_d  = in_valid;
    if (in_valid) begin
      min1_d       = w_root_min;
      min2_d       = w_root_sec;
      min1_index_d = w_root_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min1_q       <= '0;
      min2_q       <= '0;
      min1_index_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      min1_q       <= min1_d;
      min2_q       <= min2_d;
      min1_index_q <= min1_index_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign min1       = min1_q;
  assign min2       = min2_q;
  assign min1_index = min1_index_q;
  assign out_valid  = out_valid_q;

endmodule : min_sum_tree_8
`default_nettype wire

// File: tb/tb_min_sum_tree_8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_min_sum_tree_8
//  Purpose  : Self-checking bench for min_sum_tree_8: directed vector table,
//             back-to-back, hold, reset corner cases and a random sweep
//             against a sort-based reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_min_sum_tree_8;
  import min_sum_pkg::*;

  localparam int W = 5;

  typedef struct {
    logic [7:0][W-1:0] xs;
    int                m1;
    int                m2;
    int                idx;
  } vec_t;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_fail;

  vec_t vecs[$];

  min_sum_tree_8_if #(.W(W)) bus (.clk(clk));

  min_sum_tree_8 #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (bus.in_valid),
    .x0         (bus.x0),
    .x1         (bus.x1),
    .x2         (bus.x2),
    .x3         (bus.x3),
    .x4         (bus.x4),
    .x5         (bus.x5),
    .x6         (bus.x6),
    .x7         (bus.x7),
    .min1       (bus.min1),
    .min2       (bus.min2),
    .min1_index (bus.min1_index),
    .out_valid  (bus.out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int a0, input int a1, input int a2, input int a3,
                         input int a4, input int a5, input int a6, input int a7,
                         input int m1, input int m2, input int idx);
    vec_t v;
    v.xs[0] = W'(a0); v.xs[1] = W'(a1); v.xs[2] = W'(a2); v.xs[3] = W'(a3);
    v.xs[4] = W'(a4); v.xs[5] = W'(a5); v.xs[6] = W'(a6); v.xs[7] = W'(a7);
    v.m1 = m1; v.m2 = m2; v.idx = idx;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [7:0][W-1:0] xs, input logic vld);
    bus.in_valid = vld;
    bus.x0 = xs[0]; bus.x1 = xs[1]; bus.x2 = xs[2]; bus.x3 = xs[3];
    bus.x4 = xs[4]; bus.x5 = xs[5]; bus.x6 = xs[6]; bus.x7 = xs[7];
  endtask

  task automatic check_result(input string tag, input int m1, input int m2,
                              input int idx, input int vld);
    check({tag, ".min1"},       int'(bus.min1),       m1);
    check({tag, ".min2"},       int'(bus.min2),       m2);
    check({tag, ".min1_index"}, int'(bus.min1_index), idx);
    check({tag, ".out_valid"},  int'(bus.out_valid),  vld);
  endtask

  // Reference: first strict minimum for the index, sorted copy for min2.
  task automatic ref_model(input logic [7:0][W-1:0] xs,
                           output int m1, output int m2, output int idx);
    int s[8];
    int t;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      s[i] = int'(xs[i]);
      if (int'(xs[i]) < int'(xs[idx])) idx = i;
    end
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    m1 = s[0];
    m2 = s[1];
  endtask

  initial begin
    logic [7:0][W-1:0] xs;
    logic [7:0][W-1:0] zero_xs;
    int e1, e2, ei;
    int p1, p2, pi;
    int mode, base;

    n_cmp   = 0;
    n_fail  = 0;
    zero_xs = '0;

    add_vec( 1, 12,  0,  4,  2, 13, 10,  0,   0,  0, 2);
    add_vec( 9,  7,  5,  3,  8,  6,  4,  2,   2,  3, 7);
    add_vec(31, 31, 31, 31, 31, 31, 31, 31,  31, 31, 0);
    add_vec( 7,  7,  7,  7,  7,  7,  7,  7,   7,  7, 0);
    add_vec( 6,  6,  6,  6,  6,  6,  6,  1,   1,  6, 7);
    add_vec( 0, 31, 31, 31, 31, 31, 31, 31,   0, 31, 0);
    add_vec(20, 15, 15, 30, 25, 15, 16, 17,  15, 15, 1);
    add_vec(31, 30, 29, 28, 27, 26, 25, 24,  24, 25, 7);
    add_vec( 9,  9,  9,  9,  2,  9,  9,  2,   2,  2, 4);
    add_vec( 8,  8,  8,  8,  8,  8,  3,  4,   3,  4, 6);
    add_vec(10,  5, 11, 12, 13, 14, 15,  6,   5,  6, 1);

    // Reset state, with a valid input presented during reset.
    rst_n = 1'b0;
    drive(zero_xs, 1'b0);
    #1;
    check_result("reset", 0, 0, 0, 0);
    xs = vecs[1].xs;
    drive(xs, 1'b1);
    @(posedge clk); #1;
    check_result("in_reset_discard", 0, 0, 0, 0);
    @(negedge clk);
    drive(zero_xs, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset.out_valid", int'(bus.out_valid), 0);

    // Directed table, streamed back-to-back.
    for (int k = 0; k <= vecs.size(); k++) begin
      if (k > 0)
        check_result($sformatf("vec%0d", k - 1),
                     vecs[k-1].m1, vecs[k-1].m2, vecs[k-1].idx, 1);
      if (k < vecs.size()) drive(vecs[k].xs, 1'b1);
      else                 drive(zero_xs, 1'b0);
      @(negedge clk);
    end
    // Hold while idle: last result stays, out_valid drops.
    check_result("hold", vecs[vecs.size()-1].m1, vecs[vecs.size()-1].m2,
                 vecs[vecs.size()-1].idx, 0);

    // Back-to-back pair followed by idle.
    add_vec( 4,  1,  9,  9,  9,  9,  9,  9,   1,  4, 1);
    add_vec( 9,  9,  9,  9,  9,  9,  3,  5,   3,  5, 6);
    drive(vecs[vecs.size()-2].xs, 1'b1);
    @(negedge clk);
    check_result("b2b_first", 1, 4, 1, 1);
    drive(vecs[vecs.size()-1].xs, 1'b1);
    @(negedge clk);
    check_result("b2b_second", 3, 5, 6, 1);
    drive(zero_xs, 1'b0);
    @(negedge clk);
    check_result("b2b_idle", 3, 5, 6, 0);

    // Asynchronous reset mid-cycle right after a result is registered.
    drive(vecs[0].xs, 1'b1);
    @(posedge clk); #1;
    check_result("pre_abort", 0, 0, 2, 1);
    drive(vecs[1].xs, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_result("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    drive(zero_xs, 1'b0);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_result("after_release", 0, 0, 0, 0);
    end

    // Random sweep, pipelined: check the previous vector while driving the next.
    p1 = 0; p2 = 0; pi = 0;
    for (int k = 0; k <= 10000; k++) begin
      if (k > 0) begin
        check("rnd.min1",       int'(bus.min1),       p1);
        check("rnd.min2",       int'(bus.min2),       p2);
        check("rnd.min1_index", int'(bus.min1_index), pi);
        check("rnd.out_valid",  int'(bus.out_valid),  1);
      end
      if (k < 10000) begin
        mode = int'($urandom_range(0, 2));
        base = int'($urandom_range(0, 31));
        for (int i = 0; i < 8; i++) begin
          case (mode)
            0:       xs[i] = W'($urandom_range(0, 31));
            1:       xs[i] = W'($urandom_range(0, 3));
            default: xs[i] = W'($urandom_range(base, 31));
          endcase
        end
        if (mode == 2) begin
          xs[$urandom_range(0, 7)] = W'(base);
          xs[$urandom_range(0, 7)] = W'(base);
        end
        ref_model(xs, e1, e2, ei);
        p1 = e1; p2 = e2; pi = ei;
        drive(xs, 1'b1);
      end else begin
        drive(zero_xs, 1'b0);
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_min_sum_tree_8
`default_nettype wire
